// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store unit with alignment checks, lane steering, load extension and bus timeout
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_size,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [2:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  misaligned, illegal;
  logic [OW-1:0]         off;
  logic [NB-1:0]         size_mask;
  logic [DATA_WIDTH-1:0] shifted, load_fmt;
  assign misaligned = req_size[1:0] == 2'd0 ? 1'b0 :
                      req_size[1:0] == 2'd1 ? req_addr[0] :
                      req_size[1:0] == 2'd2 ? |req_addr[1:0] : |req_addr[2:0];
  assign illegal = req_size == 3'b111 || misaligned ||
                   (DATA_WIDTH == 32 && (req_size == 3'b011 || req_size == 3'b110));
  assign off       = addr_q[OW-1:0];
  assign size_mask = NB'(size_q[1:0] == 2'd0 ? 8'h01 : size_q[1:0] == 2'd1 ? 8'h03 :
                         size_q[1:0] == 2'd2 ? 8'h0F : 8'hFF);
  assign shifted   = mem_rdata >> {off, 3'b000};
  assign load_fmt  = size_q == 3'b000 ? DATA_WIDTH'($signed(shifted[7:0])) :
                     size_q == 3'b100 ? DATA_WIDTH'(shifted[7:0]) :
                     size_q == 3'b001 ? DATA_WIDTH'($signed(shifted[15:0])) :
                     size_q == 3'b101 ? DATA_WIDTH'(shifted[15:0]) :
                     size_q == 3'b010 ? DATA_WIDTH'($signed(shifted[31:0])) :
                     size_q == 3'b110 ? DATA_WIDTH'(shifted[31:0]) : shifted;
  assign req_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign mem_valid  = state_q == REQ;
  assign mem_we     = mem_valid & we_q;
  assign mem_addr   = mem_valid ? {addr_q[ADDR_WIDTH-1:OW], OW'(0)} : '0;
  assign mem_be     = mem_valid ? size_mask << off : '0;
  assign mem_wdata  = !mem_valid ? '0 :
                      size_q[1:0] == 2'd0 ? {NB{wdata_q[7:0]}} :
                      size_q[1:0] == 2'd1 ? {(NB/2){wdata_q[15:0]}} :
                      size_q[1:0] == 2'd2 ? {(NB/4){wdata_q[31:0]}} : wdata_q;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;
  // Next-state: accept/reject in IDLE, bus handshake in REQ, data or timeout in WAIT
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        err_d   = illegal;
        rdata_d = '0;
        cnt_d   = '0;
        state_d = illegal ? RESP : REQ;
      end
      REQ: if (mem_ready) begin
        cnt_d   = '0;
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: if (mem_rvalid) begin
        rdata_d = load_fmt;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end
  // State and latched request registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data/bus width; legal values 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter TIMEOUT, default 16, maximum WAIT cycles before bus error; must be >= 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  CPU access request.
REQ-007 req_ready  output  1  LSU can accept a request.
REQ-008 req_we  input  1  1=store, 0=load.
REQ-009 req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  DATA_WIDTH  store data, LSB-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned, illegal size or timeout; valid with resp_valid.
REQ-015 busy  output  1  CPU stall; high in every state except IDLE.
REQ-016 mem_valid  output  1  memory request.
REQ-017 mem_ready  input  1  memory accepts request.
REQ-018 mem_we  output  1  write strobe.
REQ-019 mem_addr  output  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits 0).
REQ-020 mem_be  output  DATA_WIDTH/8  byte enables.
REQ-021 mem_wdata  output  DATA_WIDTH  lane-replicated store data.
REQ-022 mem_rvalid  input  1  load data valid.
REQ-023 mem_rdata  input  DATA_WIDTH  full-word load data.

Function
REQ-024 FSM states: IDLE, REQ, WAIT, RESP.
REQ-025 IDLE: req_ready=1; on req_valid, latch we/size/addr/wdata; go to RESP with error if the access is illegal, else to REQ.
REQ-026 Illegal access: offset not a multiple of access size, size 111, or size 011/110 when DATA_WIDTH=32.
REQ-027 REQ: mem_valid=1, with mem_we/mem_addr/mem_be/mem_wdata stable until mem_ready; on mem_ready, store goes to RESP and load goes to WAIT.
REQ-028 WAIT: on mem_rvalid, capture the formatted load data and go to RESP; mem_rvalid in any other state is ignored.
REQ-029 WAIT counter: cleared on entry, incremented each cycle without mem_rvalid; at count == TIMEOUT go to RESP with err=1 and rdata=0.
REQ-030 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in RESP (no back-to-back acceptance).
REQ-031 Minimum latency: legal store, resp_valid 2 cycles after acceptance with mem_ready=1 at the first opportunity; load, 3 cycles with mem_rvalid on the first WAIT cycle; illegal access, 1 cycle.
REQ-032 mem_be = (size mask: 1/3/F/FF for B/H/W/D) << offset; mem_be=0 and mem_valid=0 outside REQ.
REQ-033 mem_wdata: byte replicated to all lanes, half to all half-lanes, word to all word-lanes; D passed through.
REQ-034 Load extraction: select lane at offset, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to DATA_WIDTH; W on DATA_WIDTH=32 passes through.
REQ-035 resp_rdata and resp_err are held registered and driven to 0 whenever resp_valid=0.

Reset
REQ-036 rst low forces IDLE immediately: req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-037 Reset during REQ/WAIT abandons the access; no response is produced, and a later mem_rvalid is ignored.

Verification (DATA_WIDTH=32, TIMEOUT=16)
REQ-038 SB addr 0x103 wdata 0x000000AB, mem_ready=1 -> mem_addr 0x100, mem_be 1000, mem_wdata 0xABABABAB; resp_valid 2 cycles after accept, err=0, rdata=0.
REQ-039 LB addr 0x102, mem_rdata 0x12F45678 -> resp_rdata 0xFFFFFFF4; same access as LBU -> 0x000000F4; LHU addr 0x102 -> 0x000012F4.
REQ-040 LH addr 0x101 -> mem_valid never asserted; resp_valid 1 cycle after accept, err=1, rdata=0; size 011 -> same response.
REQ-041 SW with mem_ready held low 5 cycles -> mem_valid and mem_* outputs stable, busy=1, req_ready=0 throughout; completes after mem_ready.
REQ-042 LW with mem_rvalid never asserted -> resp_valid with err=1 and rdata=0 exactly 16 WAIT cycles after entering WAIT.
REQ-043 rst low during WAIT, then mem_rvalid after release -> no resp_valid; req_ready=1; next LW at 0x200 completes normally.
